// File: rtl/rn_rename.sv
// rn_rename: 4-wide rename stage. Speculative RAT plus circular free list for
// allocation, committed RAT (CRAT) for flush recovery, registered DS_* group.
module rn_rename #(
  parameter int NUM_PREG = 64,
  parameter int PREG_W   = 6,
  parameter int FL_DEPTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  ds_stall,
  input  logic                  RN_Inst1_Instvalid,
  input  logic                  RN_Inst1_RegW,
  input  logic [4:0]            RN_Inst1_Src1,
  input  logic [4:0]            RN_Inst1_Src2,
  input  logic [4:0]            RN_Inst1_Rdst,
  input  logic [8:0]            RN_Inst1_ALUop,
  input  logic [31:0]           RN_Inst1_Extend_imm,
  input  logic [31:0]           RN_Inst1_PC,
  input  logic                  RN_Inst2_Instvalid,
  input  logic                  RN_Inst2_RegW,
  input  logic [4:0]            RN_Inst2_Src1,
  input  logic [4:0]            RN_Inst2_Src2,
  input  logic [4:0]            RN_Inst2_Rdst,
  input  logic [8:0]            RN_Inst2_ALUop,
  input  logic [31:0]           RN_Inst2_Extend_imm,
  input  logic                  RN_Inst3_Instvalid,
  input  logic                  RN_Inst3_RegW,
  input  logic [4:0]            RN_Inst3_Src1,
  input  logic [4:0]            RN_Inst3_Src2,
  input  logic [4:0]            RN_Inst3_Rdst,
  input  logic [8:0]            RN_Inst3_ALUop,
  input  logic [31:0]           RN_Inst3_Extend_imm,
  input  logic                  RN_Inst4_Instvalid,
  input  logic                  RN_Inst4_RegW,
  input  logic [4:0]            RN_Inst4_Src1,
  input  logic [4:0]            RN_Inst4_Src2,
  input  logic [4:0]            RN_Inst4_Rdst,
  input  logic [8:0]            RN_Inst4_ALUop,
  input  logic [31:0]           RN_Inst4_Extend_imm,
  output logic                  rn_stall,
  output logic                  DS_Inst1_Valid,
  output logic [PREG_W-1:0]     DS_Inst1_PSrc1,
  output logic [PREG_W-1:0]     DS_Inst1_PSrc2,
  output logic [PREG_W-1:0]     DS_Inst1_PDst,
  output logic [PREG_W-1:0]     DS_Inst1_OldPDst,
  output logic [8:0]            DS_Inst1_ALUop,
  output logic [31:0]           DS_Inst1_Extend_imm,
  output logic [31:0]           DS_Inst1_PC,
  output logic                  DS_Inst2_Valid,
  output logic [PREG_W-1:0]     DS_Inst2_PSrc1,
  output logic [PREG_W-1:0]     DS_Inst2_PSrc2,
  output logic [PREG_W-1:0]     DS_Inst2_PDst,
  output logic [PREG_W-1:0]     DS_Inst2_OldPDst,
  output logic [8:0]            DS_Inst2_ALUop,
  output logic [31:0]           DS_Inst2_Extend_imm,
  output logic                  DS_Inst3_Valid,
  output logic [PREG_W-1:0]     DS_Inst3_PSrc1,
  output logic [PREG_W-1:0]     DS_Inst3_PSrc2,
  output logic [PREG_W-1:0]     DS_Inst3_PDst,
  output logic [PREG_W-1:0]     DS_Inst3_OldPDst,
  output logic [8:0]            DS_Inst3_ALUop,
  output logic [31:0]           DS_Inst3_Extend_imm,
  output logic                  DS_Inst4_Valid,
  output logic [PREG_W-1:0]     DS_Inst4_PSrc1,
  output logic [PREG_W-1:0]     DS_Inst4_PSrc2,
  output logic [PREG_W-1:0]     DS_Inst4_PDst,
  output logic [PREG_W-1:0]     DS_Inst4_OldPDst,
  output logic [8:0]            DS_Inst4_ALUop,
  output logic [31:0]           DS_Inst4_Extend_imm,
  input  logic [3:0]            cm_valid,
  input  logic [4*5-1:0]        cm_rdst,
  input  logic [4*PREG_W-1:0]   cm_pdst,
  input  logic [4*PREG_W-1:0]   cm_oldpdst
);

  localparam int NARCH = 32;
  localparam int FL_AW = $clog2(FL_DEPTH);
  localparam int PW    = FL_AW + 1;

  logic [3:0]              inst_valid, inst_regw;
  logic [3:0][4:0]         src1_a, src2_a, rdst_a;
  logic [3:0][8:0]         aluop_a;
  logic [3:0][31:0]        imm_a;
  logic [3:0][4:0]         cm_rd;
  logic [3:0][PREG_W-1:0]  cm_pd, cm_op;

  assign inst_valid = {RN_Inst4_Instvalid, RN_Inst3_Instvalid, RN_Inst2_Instvalid, RN_Inst1_Instvalid};
  assign inst_regw  = {RN_Inst4_RegW, RN_Inst3_RegW, RN_Inst2_RegW, RN_Inst1_RegW};
  assign src1_a     = {RN_Inst4_Src1, RN_Inst3_Src1, RN_Inst2_Src1, RN_Inst1_Src1};
  assign src2_a     = {RN_Inst4_Src2, RN_Inst3_Src2, RN_Inst2_Src2, RN_Inst1_Src2};
  assign rdst_a     = {RN_Inst4_Rdst, RN_Inst3_Rdst, RN_Inst2_Rdst, RN_Inst1_Rdst};
  assign aluop_a    = {RN_Inst4_ALUop, RN_Inst3_ALUop, RN_Inst2_ALUop, RN_Inst1_ALUop};
  assign imm_a      = {RN_Inst4_Extend_imm, RN_Inst3_Extend_imm, RN_Inst2_Extend_imm, RN_Inst1_Extend_imm};
  assign cm_rd      = cm_rdst;
  assign cm_pd      = cm_pdst;
  assign cm_op      = cm_oldpdst;

  logic [PREG_W-1:0]       rat [NARCH];
  logic [PREG_W-1:0]       rat_next [NARCH];
  logic [PREG_W-1:0]       crat [NARCH];
  logic [PREG_W-1:0]       crat_next [NARCH];
  logic [PREG_W-1:0]       fl [FL_DEPTH];
  logic [PW-1:0]           head, chead, tail, fl_count;
  logic [PW-1:0]           chead_next, tail_next;
  logic [3:0]              alloc;
  logic [2:0]              need, pushes;
  logic [FL_AW-1:0]        pop_idx;
  logic [3:0][PREG_W-1:0]  pdst_c, opdst_c, psrc1_c, psrc2_c;
  logic [3:0]              push_en;
  logic [3:0][FL_AW-1:0]   push_idx;
  logic                    fire;

  logic [3:0]              ds_valid_q;
  logic [3:0][PREG_W-1:0]  ds_ps1_q, ds_ps2_q, ds_pd_q, ds_opd_q;
  logic [3:0][8:0]         ds_alu_q;
  logic [3:0][31:0]        ds_imm_q;
  logic [31:0]             ds_pc_q;

  // Rename the group in slot order; rat_next doubles as the running map so that
  // each slot sees the youngest earlier writer in the group.
  always_comb begin
    need    = '0;
    pop_idx = '0;
    for (int unsigned i = 0; i < NARCH; i++) rat_next[i] = rat[i];
    for (int unsigned k = 0; k < 4; k++) begin
      alloc[k]   = inst_valid[k] & inst_regw[k] & (rdst_a[k] != '0);
      psrc1_c[k] = (src1_a[k] == '0) ? '0 : rat_next[src1_a[k]];
      psrc2_c[k] = (src2_a[k] == '0) ? '0 : rat_next[src2_a[k]];
      pdst_c[k]  = '0;
      opdst_c[k] = '0;
      if (alloc[k]) begin
        pop_idx              = head[FL_AW-1:0] + FL_AW'(need);
        pdst_c[k]            = fl[pop_idx];
        opdst_c[k]           = rat_next[rdst_a[k]];
        rat_next[rdst_a[k]]  = pdst_c[k];
        need                 = need + 3'd1;
      end
    end
  end

  assign rn_stall = ds_stall | (PW'(need) > fl_count);
  assign fire     = ~rn_stall;

  // Apply commits in slot order: CRAT update (later slot wins) and free-list pushes.
  always_comb begin
    for (int unsigned i = 0; i < NARCH; i++) crat_next[i] = crat[i];
    chead_next = chead;
    tail_next  = tail;
    pushes     = '0;
    push_en    = '0;
    push_idx   = '0;
    for (int unsigned p = 0; p < 4; p++) begin
      if (cm_valid[p] && (cm_rd[p] != '0)) begin
        crat_next[cm_rd[p]] = cm_pd[p];
        push_en[p]          = 1'b1;
        push_idx[p]         = tail_next[FL_AW-1:0];
        tail_next           = tail_next + PW'(1);
        chead_next          = chead_next + PW'(1);
        pushes              = pushes + 3'd1;
      end
    end
  end

  // Map tables, free list and pointers.
  // tail resets to index 0 with its wrap bit set, so tail - chead reads 32 (full).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NARCH; i++) begin
        rat[i]  <= PREG_W'(i);
        crat[i] <= PREG_W'(i);
      end
      for (int unsigned i = 0; i < FL_DEPTH; i++) fl[i] <= PREG_W'(NUM_PREG - FL_DEPTH + int'(i));
      head     <= '0;
      chead    <= '0;
      tail     <= PW'(FL_DEPTH);
      fl_count <= PW'(FL_DEPTH);
    end else begin
      for (int unsigned p = 0; p < 4; p++) begin
        if (push_en[p]) fl[push_idx[p]] <= cm_op[p];
      end
      crat  <= crat_next;
      chead <= chead_next;
      tail  <= tail_next;
      if (flush) begin
        rat      <= crat_next;
        head     <= chead_next;
        fl_count <= tail_next - chead_next;
      end else begin
        if (fire) begin
          rat  <= rat_next;
          head <= head + PW'(need);
        end
        fl_count <= fl_count + PW'(pushes) - (fire ? PW'(need) : PW'(0));
      end
    end
  end

  // Output register toward dispatch: clear, hold, load, or bubble.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ds_valid_q <= '0;
      ds_ps1_q   <= '0;
      ds_ps2_q   <= '0;
      ds_pd_q    <= '0;
      ds_opd_q   <= '0;
      ds_alu_q   <= '0;
      ds_imm_q   <= '0;
      ds_pc_q    <= '0;
    end else if (ds_stall) begin
      ds_valid_q <= ds_valid_q;
    end else if (fire) begin
      ds_valid_q <= inst_valid;
      ds_ps1_q   <= psrc1_c;
      ds_ps2_q   <= psrc2_c;
      ds_pd_q    <= pdst_c;
      ds_opd_q   <= opdst_c;
      ds_alu_q   <= aluop_a;
      ds_imm_q   <= imm_a;
      ds_pc_q    <= RN_Inst1_PC;
    end else begin
      ds_valid_q <= '0;
    end
  end

  assign DS_Inst1_Valid      = ds_valid_q[0];
  assign DS_Inst1_PSrc1      = ds_ps1_q[0];
  assign DS_Inst1_PSrc2      = ds_ps2_q[0];
  assign DS_Inst1_PDst       = ds_pd_q[0];
  assign DS_Inst1_OldPDst    = ds_opd_q[0];
  assign DS_Inst1_ALUop      = ds_alu_q[0];
  assign DS_Inst1_Extend_imm = ds_imm_q[0];
  assign DS_Inst1_PC         = ds_pc_q;
  assign DS_Inst2_Valid      = ds_valid_q[1];
  assign DS_Inst2_PSrc1      = ds_ps1_q[1];
  assign DS_Inst2_PSrc2      = ds_ps2_q[1];
  assign DS_Inst2_PDst       = ds_pd_q[1];
  assign DS_Inst2_OldPDst    = ds_opd_q[1];
  assign DS_Inst2_ALUop      = ds_alu_q[1];
  assign DS_Inst2_Extend_imm = ds_imm_q[1];
  assign DS_Inst3_Valid      = ds_valid_q[2];
  assign DS_Inst3_PSrc1      = ds_ps1_q[2];
  assign DS_Inst3_PSrc2      = ds_ps2_q[2];
  assign DS_Inst3_PDst       = ds_pd_q[2];
  assign DS_Inst3_OldPDst    = ds_opd_q[2];
  assign DS_Inst3_ALUop      = ds_alu_q[2];
  assign DS_Inst3_Extend_imm = ds_imm_q[2];
  assign DS_Inst4_Valid      = ds_valid_q[3];
  assign DS_Inst4_PSrc1      = ds_ps1_q[3];
  assign DS_Inst4_PSrc2      = ds_ps2_q[3];
  assign DS_Inst4_PDst       = ds_pd_q[3];
  assign DS_Inst4_OldPDst    = ds_opd_q[3];
  assign DS_Inst4_ALUop      = ds_alu_q[3];
  assign DS_Inst4_Extend_imm = ds_imm_q[3];

endmodule

// File: tb/tb_rn_rename.sv
// tb_rn_rename: directed vectors for rn_rename plus a wrap-around scoreboard run.
module tb_rn_rename;

  logic clk = 1'b0;
  logic rst, flush, ds_stall;
  logic [3:0]       iv, rw;
  logic [3:0][4:0]  s1, s2, rd;
  logic [3:0][8:0]  alu;
  logic [3:0][31:0] imm;
  logic [31:0]      pc;
  logic [3:0]       cmv;
  logic [3:0][4:0]  cmrd;
  logic [3:0][5:0]  cmpd, cmop;

  wire              rn_stall;
  wire [3:0]        dv;
  wire [3:0][5:0]   ps1, ps2, pd, opd;
  wire [3:0][8:0]   dalu;
  wire [3:0][31:0]  dimm;
  wire [31:0]       dpc;

  int nvec = 0;
  int nerr = 0;

  logic             busy [64];
  logic [5:0]       mrat [32];
  logic [1:0]       pend_v;
  logic [1:0][5:0]  pend_op;

  always #5 clk = ~clk;

  rn_rename #(.NUM_PREG(64), .PREG_W(6), .FL_DEPTH(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .ds_stall(ds_stall),
    .RN_Inst1_Instvalid(iv[0]), .RN_Inst1_RegW(rw[0]), .RN_Inst1_Src1(s1[0]), .RN_Inst1_Src2(s2[0]),
    .RN_Inst1_Rdst(rd[0]), .RN_Inst1_ALUop(alu[0]), .RN_Inst1_Extend_imm(imm[0]), .RN_Inst1_PC(pc),
    .RN_Inst2_Instvalid(iv[1]), .RN_Inst2_RegW(rw[1]), .RN_Inst2_Src1(s1[1]), .RN_Inst2_Src2(s2[1]),
    .RN_Inst2_Rdst(rd[1]), .RN_Inst2_ALUop(alu[1]), .RN_Inst2_Extend_imm(imm[1]),
    .RN_Inst3_Instvalid(iv[2]), .RN_Inst3_RegW(rw[2]), .RN_Inst3_Src1(s1[2]), .RN_Inst3_Src2(s2[2]),
    .RN_Inst3_Rdst(rd[2]), .RN_Inst3_ALUop(alu[2]), .RN_Inst3_Extend_imm(imm[2]),
    .RN_Inst4_Instvalid(iv[3]), .RN_Inst4_RegW(rw[3]), .RN_Inst4_Src1(s1[3]), .RN_Inst4_Src2(s2[3]),
    .RN_Inst4_Rdst(rd[3]), .RN_Inst4_ALUop(alu[3]), .RN_Inst4_Extend_imm(imm[3]),
    .rn_stall(rn_stall),
    .DS_Inst1_Valid(dv[0]), .DS_Inst1_PSrc1(ps1[0]), .DS_Inst1_PSrc2(ps2[0]), .DS_Inst1_PDst(pd[0]),
    .DS_Inst1_OldPDst(opd[0]), .DS_Inst1_ALUop(dalu[0]), .DS_Inst1_Extend_imm(dimm[0]), .DS_Inst1_PC(dpc),
    .DS_Inst2_Valid(dv[1]), .DS_Inst2_PSrc1(ps1[1]), .DS_Inst2_PSrc2(ps2[1]), .DS_Inst2_PDst(pd[1]),
    .DS_Inst2_OldPDst(opd[1]), .DS_Inst2_ALUop(dalu[1]), .DS_Inst2_Extend_imm(dimm[1]),
    .DS_Inst3_Valid(dv[2]), .DS_Inst3_PSrc1(ps1[2]), .DS_Inst3_PSrc2(ps2[2]), .DS_Inst3_PDst(pd[2]),
    .DS_Inst3_OldPDst(opd[2]), .DS_Inst3_ALUop(dalu[2]), .DS_Inst3_Extend_imm(dimm[2]),
    .DS_Inst4_Valid(dv[3]), .DS_Inst4_PSrc1(ps1[3]), .DS_Inst4_PSrc2(ps2[3]), .DS_Inst4_PDst(pd[3]),
    .DS_Inst4_OldPDst(opd[3]), .DS_Inst4_ALUop(dalu[3]), .DS_Inst4_Extend_imm(dimm[3]),
    .cm_valid(cmv), .cm_rdst(cmrd), .cm_pdst(cmpd), .cm_oldpdst(cmop)
  );

  // Free-list occupancy must never exceed its depth.
  always @(negedge clk) begin
    if (rst === 1'b0) assert (dut.fl_count <= 6'd32) else $error("FAIL fl_overflow: fl_count %0d above 32", dut.fl_count);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    iv = '0; rw = '0; s1 = '0; s2 = '0; rd = '0; alu = '0; imm = '0; pc = '0;
    cmv = '0; cmrd = '0; cmpd = '0; cmop = '0;
  endtask

  task automatic set_slot(input int k, input logic [4:0] d, input logic [4:0] a, input logic [4:0] b);
    iv[k] = 1'b1; rw[k] = 1'b1; rd[k] = d; s1[k] = a; s2[k] = b;
  endtask

  task automatic set_cm(input int p, input logic [4:0] d, input logic [5:0] npd, input logic [5:0] op);
    cmv[p] = 1'b1; cmrd[p] = d; cmpd[p] = npd; cmop[p] = op;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; ds_stall = 1'b0;
    clr_in();
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    #1;
    check("rst_valid", dv, 0);
    check("rst_stall", rn_stall, 0);
    check("rst_count", dut.fl_count, 32);

    // add r1<-r2,r3; add r4<-r1,r1; nop; add r1<-r1,r0
    set_slot(0, 1, 2, 3);
    set_slot(1, 4, 1, 1);
    iv[2] = 1'b1;
    set_slot(3, 1, 1, 0);
    for (int k = 0; k < 4; k++) begin alu[k] = 9'h10 + 9'(k); imm[k] = 32'hA000_0000 + 32'(k); end
    pc = 32'h0000_1000;
    #1;
    check("grp_stall", rn_stall, 0);
    tick();
    check("grp_valid", dv, 4'b1111);
    check("i1_pdst", pd[0], 32);
    check("i1_psrc1", ps1[0], 2);
    check("i1_psrc2", ps2[0], 3);
    check("i1_old", opd[0], 1);
    check("i2_psrc1", ps1[1], 32);
    check("i2_psrc2", ps2[1], 32);
    check("i2_pdst", pd[1], 33);
    check("i2_old", opd[1], 4);
    check("i3_pdst", pd[2], 0);
    check("i3_old", opd[2], 0);
    check("i4_psrc1", ps1[3], 32);
    check("i4_psrc2", ps2[3], 0);
    check("i4_pdst", pd[3], 34);
    check("i4_old", opd[3], 32);
    check("rat1", dut.rat[1], 34);
    check("rat4", dut.rat[4], 33);
    check("grp_count", dut.fl_count, 29);
    check("alu4", dalu[3], 9'h13);
    check("imm2", dimm[1], 32'hA000_0001);
    check("pc", dpc, 32'h0000_1000);
    clr_in();
    tick();
    check("idle_valid", dv, 0);

    // Rdst=0 with RegW=1 takes nothing from the free list
    set_slot(0, 0, 4, 0);
    tick();
    check("r0_valid", dv[0], 1);
    check("r0_pdst", pd[0], 0);
    check("r0_psrc1", ps1[0], 33);
    check("r0_count", dut.fl_count, 29);

    // Drain 27 entries leaving 2 (fl[30]=62, fl[31]=63)
    for (int g = 0; g < 7; g++) begin
      clr_in();
      for (int k = 0; k < 4; k++) if (g < 6 || k < 3) set_slot(k, 5, 0, 0);
      tick();
    end
    check("drain_valid", dv, 4'b0111);
    check("drain_pd0", pd[0], 59);
    check("drain_pd2", pd[2], 61);
    check("drain_count", dut.fl_count, 2);
    clr_in();
    for (int k = 0; k < 4; k++) set_slot(k, 5'(9 + k), 0, 0);
    #1;
    check("short_stall", rn_stall, 1);
    tick();
    check("short_bubble", dv, 0);
    set_cm(0, 1, 32, 1);
    set_cm(1, 4, 33, 4);
    #1;
    check("short_stall_cm", rn_stall, 1);
    tick();
    check("short_bubble_cm", dv, 0);
    check("short_count", dut.fl_count, 4);
    cmv = '0;
    #1;
    check("short_release", rn_stall, 0);
    tick();
    check("refill_valid", dv, 4'b1111);
    check("refill_pd0", pd[0], 62);
    check("refill_pd1", pd[1], 63);
    check("refill_pd2", pd[2], 1);
    check("refill_pd3", pd[3], 4);
    check("refill_count", dut.fl_count, 0);

    // Refill 4 entries (5,35,36,37), then allocate r13
    clr_in();
    set_cm(0, 5, 35, 5);
    set_cm(1, 5, 36, 35);
    set_cm(2, 5, 37, 36);
    set_cm(3, 5, 38, 37);
    tick();
    check("crat5_a", dut.crat[5], 38);
    clr_in();
    set_slot(0, 13, 5, 0);
    tick();
    check("pre_pd", pd[0], 5);
    check("pre_psrc", ps1[0], 61);
    check("pre_old", opd[0], 13);

    // ds_stall held 3 cycles with commits flowing
    clr_in();
    set_slot(0, 14, 13, 0);
    ds_stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cmv = '0;
      set_cm(0, 5, 6'(39 + c), 6'(38 + c));
      #1;
      check("ds_stall_out", rn_stall, 1);
      tick();
      check("hold_valid", dv, 4'b0001);
      check("hold_pd", pd[0], 5);
    end
    check("hold_rat14", dut.rat[14], 14);
    check("hold_crat5", dut.crat[5], 41);
    check("hold_count", dut.fl_count, 6);
    ds_stall = 1'b0;
    cmv = '0;
    tick();
    check("rel_pd", pd[0], 35);
    check("rel_psrc", ps1[0], 5);
    check("rel_old", opd[0], 14);
    check("rel_count", dut.fl_count, 5);

    // 8 speculative allocs, then flush with 3 same-cycle commits
    do_reset();
    for (int k = 0; k < 4; k++) set_slot(k, 5'(1 + k), 0, 0);
    tick();
    clr_in();
    for (int k = 0; k < 4; k++) set_slot(k, 5'(5 + k), 0, 0);
    tick();
    check("spec_count", dut.fl_count, 24);
    clr_in();
    set_slot(0, 9, 0, 0);
    set_cm(0, 1, 32, 1);
    set_cm(1, 2, 33, 2);
    set_cm(2, 3, 34, 3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_valid", dv, 0);
    check("fl_count", dut.fl_count, 32);
    check("fl_rat1", dut.rat[1], 32);
    check("fl_rat3", dut.rat[3], 34);
    check("fl_rat4", dut.rat[4], 4);
    check("fl_rat9", dut.rat[9], 9);
    check("fl_crat2", dut.crat[2], 33);
    clr_in();
    set_slot(0, 10, 1, 0);
    tick();
    check("post_fl_pd", pd[0], 35);
    check("post_fl_psrc", ps1[0], 32);
    check("post_fl_old", opd[0], 10);

    // Wrap: 2 allocs per cycle, in-order commit one cycle later, scoreboard
    do_reset();
    for (int i = 0; i < 64; i++) busy[i] = (i < 32);
    for (int i = 0; i < 32; i++) mrat[i] = 6'(i);
    pend_v = '0;
    pend_op = '0;
    for (int c = 0; c <= 100; c++) begin
      iv = '0; rw = '0;
      if (c < 100) begin
        for (int k = 0; k < 2; k++)
          set_slot(k, 5'($urandom_range(1, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      end
      #1;
      check("wrap_stall", rn_stall, 0);
      tick();
      cmv = '0;
      if (c < 100) begin
        check("wrap_valid", dv[1:0], 2'b11);
        for (int k = 0; k < 2; k++) begin
          check("wrap_psrc1", ps1[k], mrat[s1[k]]);
          check("wrap_psrc2", ps2[k], mrat[s2[k]]);
          check("wrap_old", opd[k], mrat[rd[k]]);
          check("wrap_unique", busy[pd[k]], 0);
          busy[pd[k]] = 1'b1;
          mrat[rd[k]] = pd[k];
        end
      end
      for (int k = 0; k < 2; k++) if (pend_v[k]) busy[pend_op[k]] = 1'b0;
      pend_v = '0;
      if (c < 100) begin
        for (int k = 0; k < 2; k++) begin
          set_cm(k, rd[k], pd[k], opd[k]);
          pend_v[k] = 1'b1;
          pend_op[k] = opd[k];
        end
      end
    end
    check("wrap_count", dut.fl_count, 32);
    check("wrap_head", dut.head, 6'(200 % 64));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
